// File: rtl/mem_pkg.sv
// Shared definitions for the banked data memory: access size codes, controller
// states, the time-zero preload image and small size-decoding helpers.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [31:0] PRELOAD_W0 = 32'd17;
  localparam logic [31:0] PRELOAD_W1 = 32'd9;
  localparam logic [31:0] PRELOAD_W2 = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SECOND,
    ST_RESP
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] code);
    case (code)
      MEM_H, MEM_HU: size_bytes = 3'd2;
      MEM_W:         size_bytes = 3'd4;
      default:       size_bytes = 3'd1;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic code_legal(input logic we, input logic [2:0] code);
    case (code)
      MEM_B, MEM_H, MEM_W: code_legal = 1'b1;
      MEM_BU, MEM_HU:      code_legal = !we;
      default:             code_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane_align.sv
// Byte-lane steering for one beat of a big-endian access: store data/enables
// are placed into an 8-byte window spanning the two words an access may touch.
module mem_byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  code,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic [63:0] rwindow,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [2:0]  nbytes;
  logic [3:0]  gap;
  logic [3:0]  nmask;
  logic [31:0] field_mask;
  logic [7:0]  be_pair;
  logic [63:0] wpair;
  logic [63:0] rshift;
  logic [31:0] rfield;

  always_comb begin
    nbytes = size_bytes(code);
    // Bytes between the end of the access and the end of the 8-byte window.
    gap = 4'd8 - {2'b00, offset} - {1'b0, nbytes};
    // NOTE: every case has a default so this block never holds a stale value (no latch).
    case (nbytes)
      3'd1:    nmask = 4'b0001;
      3'd2:    nmask = 4'b0011;
      default: nmask = 4'b1111;
    endcase
    field_mask = {{8{nmask[3]}}, {8{nmask[2]}}, {8{nmask[1]}}, {8{nmask[0]}}};

    wpair   = {32'd0, wdata & field_mask} << {gap, 3'b000};
    be_pair = {4'b0000, nmask} << gap;
    be      = beat ? be_pair[3:0] : be_pair[7:4];
    wword   = beat ? wpair[31:0]  : wpair[63:32];

    rshift = rwindow >> {gap, 3'b000};
    rfield = rshift[31:0] & field_mask;
    case (code)
      MEM_B:                 rdata = {{24{rfield[7]}}, rfield[7:0]};
      MEM_H:                 rdata = {{16{rfield[15]}}, rfield[15:0]};
      MEM_W, MEM_BU, MEM_HU: rdata = rfield;
      default:               rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_banked.sv
// Word-banked, byte-addressable big-endian data memory with a valid/ready
// request port, configurable latency and two-beat word-crossing accesses.
module data_mem_banked
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int EW    = ADDR_W + 3;
  localparam logic [1:0] WAIT_LAST = 2'(LATENCY - 1);

  // NOTE: storage is deliberately left out of reset; only its time-zero image is defined.
  logic [31:0] mem [WORDS] = '{0: PRELOAD_W0, 1: PRELOAD_W1, 2: PRELOAD_W2, default: 32'd0};

  state_t           state;
  logic [1:0]       wait_cnt;
  logic             cap_we;
  logic [2:0]       cap_code;
  logic [1:0]       cap_off;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_wdata;
  logic             cap_cross;
  logic [31:0]      lo_word;

  logic [2:0]       req_nbytes;
  logic [EW-1:0]    last_byte;
  logic             req_err;
  logic             req_cross;
  logic             beat1;
  logic             wait_done;
  logic             mem_we;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic [63:0]      rwindow;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wword;
  logic [31:0]      ld_data;

  always_comb begin
    req_nbytes = size_bytes(req_size);
    last_byte  = EW'(req_addr) + EW'(req_nbytes) - EW'(1);
    req_err    = !code_legal(req_we, req_size) || (last_byte >= EW'(DEPTH_BYTES));
    req_cross  = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;

    beat1     = (state == ST_SECOND);
    wait_done = (wait_cnt == WAIT_LAST);
    rd_idx    = beat1 ? cap_idx + IDX_W'(1) : cap_idx;
    rd_word   = mem[rd_idx];
    rwindow   = beat1 ? {lo_word, rd_word} : {rd_word, 32'd0};
    // A beat suppressed by rst leaves storage untouched.
    mem_we    = cap_we && !rst && ((state == ST_ACCESS && wait_done) || beat1);
  end

  mem_byte_lane_align u_align (
    .offset  (cap_off),
    .code    (cap_code),
    .beat    (beat1),
    .wdata   (cap_wdata),
    .rwindow (rwindow),
    .be      (lane_be),
    .wword   (lane_wword),
    .rdata   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[rd_idx][8*b +: 8] <= lane_wword[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_code  <= req_size;
            cap_off   <= req_addr[1:0];
            cap_idx   <= req_addr[IDX_W+1:2];
            cap_wdata <= req_wdata;
            cap_cross <= req_cross;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            state     <= req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_done) begin
            lo_word <= rd_word;
            if (cap_cross) begin
              state <= ST_SECOND;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= cap_we ? 32'd0 : ld_data;
              state      <= ST_RESP;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_SECOND: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= cap_we ? 32'd0 : ld_data;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // Entered straight from IDLE only on an error: raise the pulse one cycle later.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_banked.sv
// Scoreboard bench for data_mem_banked: one instance with LATENCY=1, one with
// LATENCY=3, each mirrored by a byte-array reference model.
module tb_data_mem_banked;
  import mem_pkg::*;

  localparam int DB = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, we0, rdy0, rv0, re0;
  logic [2:0]  sz0;
  logic [7:0]  a0;
  logic [31:0] wd0, rd0;
  logic        v1, we1, rdy1, rv1, re1;
  logic [2:0]  sz1;
  logic [7:0]  a1;
  logic [31:0] wd1, rd1;

  int          sel;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  exp_t       sb[$];
  logic [7:0] model [2][DB];
  int         tests = 0;
  int         fails = 0;

  data_mem_banked #(.ADDR_W(8), .DEPTH_BYTES(DB), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_size(sz0), .req_addr(a0), .req_wdata(wd0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
  );

  data_mem_banked #(.ADDR_W(8), .DEPTH_BYTES(DB), .LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_size(sz1), .req_addr(a1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
  );

  always_comb begin
    if (sel == 0) begin
      o_ready = rdy0; o_valid = rv0; o_err = re0; o_rdata = rd0;
    end else begin
      o_ready = rdy1; o_valid = rv1; o_err = re1; o_rdata = rd1;
    end
  end

  function automatic int size_n(input logic [2:0] sz);
    if (sz == 3'b001 || sz == 3'b101) return 2;
    if (sz == 3'b010) return 4;
    return 1;
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] sz);
    if (we) return (sz == 3'b000 || sz == 3'b001 || sz == 3'b010);
    return (sz == 3'b000 || sz == 3'b001 || sz == 3'b010 || sz == 3'b100 || sz == 3'b101);
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [2:0] sz, input int a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_n(sz); i++) v = (v << 8) | {24'd0, model[s][a+i]};
    if (sz == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (sz == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input int s, input logic [2:0] sz, input int a, input logic [31:0] wd);
    int n;
    n = size_n(sz);
    for (int i = 0; i < n; i++) model[s][a+i] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic drive(input int s, input logic v, input logic we, input logic [2:0] sz,
                       input logic [7:0] a, input logic [31:0] wd);
    if (s == 0) begin
      v0 = v; we0 = we; sz0 = sz; a0 = a; wd0 = wd;
    end else begin
      v1 = v; we1 = we; sz1 = sz; a1 = a; wd1 = wd;
    end
  endtask

  // Waits for resp_valid after an acceptance edge; n = cycles since acceptance.
  task automatic wait_resp(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 12) begin
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic do_req(input int s, input logic we, input logic [2:0] sz, input int a,
                        input logic [31:0] wd, input string name);
    exp_t e, got;
    int   n, k;
    logic busy_ok;
    n      = size_n(sz);
    e.err  = !legal(we, sz) || (a + n - 1 >= DB);
    k      = (s == 0) ? 1 : 3;
    e.lat  = e.err ? 1 : (((a % 4) + n > 4) ? k + 1 : k);
    e.rdata = (e.err || we) ? 32'd0 : model_load(s, sz, a);
    if (!e.err && we) model_store(s, sz, a, wd);
    sb.push_back(e);

    sel = s;
    @(negedge clk);
    drive(s, 1'b1, we, sz, 8'(a), wd);
    k = 0;
    while (o_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 drive(s, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    wait_resp(n, busy_ok);
    got = sb.pop_front();

    tests++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: no resp_valid within %0d cycles", name, n);
      return;
    end
    tests++;
    if (n != got.lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, n, got.lat);
    end
    tests++;
    if (o_rdata !== got.rdata) begin
      fails++; $display("FAIL %s rdata: got %h expected %h", name, o_rdata, got.rdata);
    end
    tests++;
    if (o_err !== got.err) begin
      fails++; $display("FAIL %s err: got %b expected %b", name, o_err, got.err);
    end
    tests++;
    if (busy_ok !== 1'b1) begin
      fails++; $display("FAIL %s req_ready: got high while busy, expected low", name);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s after resp: got valid=%b ready=%b expected valid=0 ready=1", name, o_valid, o_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rdy0 !== 1'b1 || rv0 !== 1'b0 || re0 !== 1'b0 || rd0 !== 32'd0) begin
      fails++; $display("FAIL reset_l1: got ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0", rdy0, rv0, re0, rd0);
    end
    tests++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || re1 !== 1'b0 || rd1 !== 32'd0) begin
      fails++; $display("FAIL reset_l3: got ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0", rdy1, rv1, re1, rd1);
    end
  endtask

  task automatic test_basic_load;
    do_req(0, 1'b0, MEM_W, 4, 32'd0, "lw4_l1");
    do_req(0, 1'b0, MEM_W, 8, 32'd0, "lw8_l1");
    do_req(1, 1'b0, MEM_W, 0, 32'd0, "lw0_l3");
  endtask

  task automatic test_byte_sign;
    do_req(0, 1'b1, MEM_B,  20, 32'h0000_0080, "sb20");
    do_req(0, 1'b0, MEM_B,  20, 32'd0, "lb20");
    do_req(0, 1'b0, MEM_BU, 20, 32'd0, "lbu20");
    do_req(0, 1'b0, MEM_H,  20, 32'd0, "lh20");
    do_req(0, 1'b0, MEM_HU, 20, 32'd0, "lhu20");
  endtask

  task automatic test_crossing;
    for (int s = 0; s < 2; s++) begin
      do_req(s, 1'b1, MEM_W, 16, 32'h1122_3344, "sw16");
      do_req(s, 1'b1, MEM_W, 20, 32'h5566_7788, "sw20");
      do_req(s, 1'b0, MEM_W, 18, 32'd0, "lw18_cross");
      do_req(s, 1'b0, MEM_H, 19, 32'd0, "lh19_cross");
      do_req(s, 1'b1, MEM_H, 23, 32'h0000_ABCD, "sh23_cross");
      do_req(s, 1'b0, MEM_W, 21, 32'd0, "lw21_cross");
    end
  endtask

  task automatic test_back_to_back;
    exp_t e, got;
    int   n, k;
    logic busy_ok;
    e.rdata = model_load(1, MEM_W, 0);
    e.err   = 1'b0;
    e.lat   = 3;
    sb.push_back(e);
    sb.push_back(e);
    sel = 1;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, MEM_W, 8'd0, 32'd0);
    k = 0;
    while (o_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    wait_resp(n, busy_ok);
    got = sb.pop_front();
    tests++;
    if (n != got.lat || o_valid !== 1'b1 || o_rdata !== got.rdata || busy_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got cycle=%0d valid=%b rdata=%h busy_ok=%b expected cycle=%0d rdata=%h",
               n, o_valid, o_rdata, busy_ok, got.lat, got.rdata);
    end
    @(negedge clk);
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_ready: got ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    wait_resp(n, busy_ok);
    got = sb.pop_front();
    tests++;
    if (n != got.lat || o_valid !== 1'b1 || o_rdata !== got.rdata) begin
      fails++;
      $display("FAIL b2b_second: got cycle=%0d valid=%b rdata=%h expected cycle=%0d rdata=%h",
               n, o_valid, o_rdata, got.lat, got.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_errors;
    do_req(0, 1'b1, MEM_BU, 8,      32'hDEAD_BEEF, "st_code100");
    do_req(0, 1'b0, MEM_W,  8,      32'd0, "lw8_unchanged");
    do_req(0, 1'b1, MEM_HU, 0,      32'hDEAD_BEEF, "st_code101");
    do_req(0, 1'b0, 3'b011, 0,      32'd0, "ld_code011");
    do_req(0, 1'b0, MEM_W,  DB - 2, 32'd0, "lw_top_minus2");
    do_req(0, 1'b0, MEM_H,  DB - 1, 32'd0, "lh_top");
    do_req(0, 1'b0, MEM_B,  DB - 1, 32'd0, "lb_top_ok");
    do_req(0, 1'b0, MEM_W,  DB - 4, 32'd0, "lw_top_ok");
    do_req(1, 1'b1, MEM_BU, 8,      32'hDEAD_BEEF, "st_code100_l3");
    do_req(1, 1'b0, MEM_W,  8,      32'd0, "lw8_unchanged_l3");
  endtask

  task automatic test_reset_split;
    logic seen;
    int   k;
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, MEM_W, 8'd30, 32'hAABB_CCDD);
    k = 0;
    while (o_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    if (o_valid === 1'b1) seen = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL split_reset_resp: got resp_valid=1 expected no response");
    end
    tests++;
    if (o_ready !== 1'b1) begin
      fails++; $display("FAIL split_reset_ready: got %b expected 1", o_ready);
    end
    model[0][30] = 8'hAA;
    model[0][31] = 8'hBB;
    do_req(0, 1'b0, MEM_BU, 30, 32'd0, "split_b30");
    do_req(0, 1'b0, MEM_BU, 31, 32'd0, "split_b31");
    do_req(0, 1'b0, MEM_BU, 32, 32'd0, "split_b32");
    do_req(0, 1'b0, MEM_BU, 33, 32'd0, "split_b33");
    do_req(0, 1'b0, MEM_W,  28, 32'd0, "split_w28");
  endtask

  task automatic test_sweep;
    logic [2:0] ld_codes [5];
    ld_codes = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
    for (int i = 0; i < 12; i++) begin
      do_req(0, 1'b1, 3'($urandom_range(0, 2)), int'($urandom_range(40, 100)), $urandom, "sweep_st");
      do_req(0, 1'b0, ld_codes[$urandom_range(0, 4)], int'($urandom_range(40, 100)), 32'd0, "sweep_ld");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 0;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < DB; b++) model[s][b] = 8'd0;
      model_store(s, MEM_W, 0, 32'd17);
      model_store(s, MEM_W, 4, 32'd9);
      model_store(s, MEM_W, 8, 32'd5);
    end
    test_reset();
    test_basic_load();
    test_byte_sign();
    test_crossing();
    test_back_to_back();
    test_errors();
    test_reset_split();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
